// File: rtl/demux_sched_pkg.sv
// Shared constants for the demux port scheduler: FSM encoding, requester count and
// the arbitration mode values.
package demux_sched_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/demux_winner_pick.sv
// Combinational winner selection: fixed priority (highest index wins) or round-robin
// starting just after the last winner.
module demux_winner_pick
  import demux_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      rr_last,
  input  logic            rr_mode,
  output logic            any_req,
  output logic [1:0]      win_idx
);

  logic [NREQ-1:0] req_ok;
  logic [1:0]      idx;
  logic            found;

  always_comb begin
    req_ok  = '0;
    idx     = '0;
    found   = 1'b0;
    win_idx = 2'd0;
    // Only a definite 1 counts as a request; X/Z falls through to not-requesting.
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) req_ok[i] = 1'b1;
    end
    any_req = |req_ok;
    if (rr_mode == MODE_RR) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = rr_last + 2'(k);
        if (!found && req_ok[idx]) begin
          win_idx = idx;
          found   = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ok[i]) win_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/demux_port_scheduler.sv
// Four-requester scheduler for a shared 1-to-4 demux: bounded bursts, one dead gap cycle
// between owners, fixed-priority or round-robin arbitration. All outputs registered.
module demux_port_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            rr_mode,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            sel_valid,
  output logic            busy,
  output logic            burst_done
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      rr_last_q, rr_last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            sel_valid_q, sel_valid_d;
  logic            busy_q, busy_d;
  logic            burst_done_q, burst_done_d;

  logic            any_req;
  logic [1:0]      win_idx;
  logic            owner_req;

  demux_winner_pick u_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .rr_mode (rr_mode),
    .any_req (any_req),
    .win_idx (win_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_last_d    = rr_last_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    sel_valid_d  = sel_valid_q;
    burst_done_d = 1'b0;
    owner_req    = 1'b0;
    if (req[sel_q]) owner_req = 1'b1;

    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d          = GRANT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          sel_d            = win_idx;
          sel_valid_d      = 1'b1;
          cnt_d            = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release on owner drop or burst exhaustion; other requesters never preempt.
        if (!owner_req || cnt_q == CNT_W'(BURST_LEN - 1)) begin
          state_d      = GAP;
          gnt_d        = '0;
          sel_valid_d  = 1'b0;
          burst_done_d = 1'b1;
          rr_last_d    = sel_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_last_q    <= 2'd3;
      gnt_q        <= '0;
      sel_q        <= 2'd0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_q    <= rr_last_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_demux_port_scheduler.sv
// Scoreboard bench: a transaction-level owner/burst model predicts each cycle's outputs for
// two scheduler instances (BURST_LEN=4 and BURST_LEN=1) driven by the same stimulus.
module tb_demux_port_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req = 4'b0000;
  logic       rr_mode = 1'b0;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       sel_valid_a, sel_valid_b, busy_a, busy_b, burst_done_a, burst_done_b;

  int tests = 0;
  int fails = 0;

  demux_port_scheduler #(.BURST_LEN(4), .CNT_W(3)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .rr_mode    (rr_mode),
    .gnt        (gnt_a),
    .sel        (sel_a),
    .sel_valid  (sel_valid_a),
    .busy       (busy_a),
    .burst_done (burst_done_a)
  );

  demux_port_scheduler #(.BURST_LEN(1), .CNT_W(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .rr_mode    (rr_mode),
    .gnt        (gnt_b),
    .sel        (sel_b),
    .sel_valid  (sel_valid_b),
    .busy       (busy_b),
    .burst_done (burst_done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owner;   // -1 when nobody holds the channel
    int used;    // cycles the current owner has held it
    bit in_gap;
    int last;    // most recent winner, for round-robin
    int sel;
    bit done;
  } mdl_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       burst_done;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];

  function automatic mdl_t model_reset();
    mdl_t m;
    m.owner = -1; m.used = 0; m.in_gap = 1'b0; m.last = 3; m.sel = 0; m.done = 1'b0;
    return m;
  endfunction

  function automatic int pick(logic [3:0] r, bit rr, int last);
    if (rr) begin
      for (int k = 1; k <= 4; k++) begin
        if (r[(last + k) % 4] === 1'b1) return (last + k) % 4;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (r[i] === 1'b1) return i;
      end
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [3:0] r, bit rr, int bl);
    int w;
    m.done = 1'b0;
    if (m.owner >= 0) begin
      if (r[m.owner] !== 1'b1 || m.used == bl) begin
        m.last = m.owner; m.owner = -1; m.in_gap = 1'b1; m.done = 1'b1;
      end else begin
        m.used++;
      end
    end else begin
      m.in_gap = 1'b0;
      w = pick(r, rr, m.last);
      if (w >= 0) begin
        m.owner = w; m.used = 1; m.sel = w;
      end
    end
    return m;
  endfunction

  function automatic exp_t predict(mdl_t m);
    exp_t e;
    e.gnt        = (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
    e.sel        = 2'(m.sel);
    e.sel_valid  = (m.owner >= 0);
    e.busy       = (m.owner >= 0) || m.in_gap;
    e.burst_done = m.done;
    return e;
  endfunction

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(string nm, exp_t act, exp_t e);
    cmp({nm, ".gnt"},        8'(act.gnt),        8'(e.gnt));
    cmp({nm, ".sel"},        8'(act.sel),        8'(e.sel));
    cmp({nm, ".sel_valid"},  8'(act.sel_valid),  8'(e.sel_valid));
    cmp({nm, ".busy"},       8'(act.busy),       8'(e.busy));
    cmp({nm, ".burst_done"}, 8'(act.burst_done), 8'(e.burst_done));
  endtask

  // Reference model: sample inputs at the active edge and queue expected outputs.
  always @(posedge clk) begin
    if (reset !== 1'b0) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ma = step(ma, req, rr_mode, 4);
      mb = step(mb, req, rr_mode, 1);
    end
    qa.push_back(predict(ma));
    qb.push_back(predict(mb));
  end

  // Monitor: sample DUT outputs just after the edge and check against the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() == 0) begin
      tests++; fails++;
      $display("FAIL a.queue: got empty expected entry at %0t", $time);
    end else begin
      e = qa.pop_front();
      cmp_all("a", {gnt_a, sel_a, sel_valid_a, busy_a, burst_done_a}, e);
    end
    if (qb.size() == 0) begin
      tests++; fails++;
      $display("FAIL b.queue: got empty expected entry at %0t", $time);
    end else begin
      e = qb.pop_front();
      cmp_all("b", {gnt_b, sel_b, sel_valid_b, busy_b, burst_done_b}, e);
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fixed priority, all requests held
    rr_mode = 1'b0; req = 4'b1011;
    repeat (12) @(negedge clk);

    // Round-robin from reset with everyone requesting
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    rr_mode = 1'b1; req = 4'b1111;
    repeat (26) @(negedge clk);
    req = 4'b0000; repeat (3) @(negedge clk);

    // Early release on the second grant cycle
    req = 4'b0010; repeat (2) @(negedge clk);
    req = 4'b0000; repeat (4) @(negedge clk);

    // Two alternating requesters (exercises the single-cycle burst instance)
    rr_mode = 1'b1; req = 4'b0101;
    repeat (12) @(negedge clk);
    req = 4'b0000; repeat (3) @(negedge clk);

    // Mode toggles while a grant is in progress
    rr_mode = 1'b0; req = 4'b1001;
    repeat (2) @(negedge clk);
    rr_mode = 1'b1; repeat (10) @(negedge clk);
    rr_mode = 1'b0; repeat (6) @(negedge clk);
    req = 4'b0000; repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a grant
    req = 4'b0100; found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #2;
      if (gnt_a == 4'b0100) found = 1'b1;
    end
    cmp("rst.wait_grant", 8'(found), 8'd1);
    reset = 1'b1; #1;
    cmp("rst.async_gnt",       8'(gnt_a),       8'h00);
    cmp("rst.async_sel_valid", 8'(sel_valid_a), 8'h00);
    cmp("rst.async_busy",      8'(busy_a),      8'h00);
    cmp("rst.async_sel",       8'(sel_a),       8'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; req = 4'b0000;
    repeat (2) @(negedge clk);

    // Randomized traffic with sticky requests, mode flips and rare resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      reset = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset = 1'b0; req = 4'b0000;
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
